// File: rtl/mrelbp_ci_frame_ctrl_if.sv
// Handshake/status bundle between the pixel source, the frame controller
// and the line-buffer/CI datapath.
interface mrelbp_ci_frame_ctrl_if #(
  parameter int CW = 8
);
  logic          start_i;
  logic          done_i;
  logic          ci_done_i;
  logic          lb_shift_o;
  logic          win_valid_o;
  logic [CW-1:0] row_o;
  logic [CW-1:0] col_o;
  logic          busy_o;
  logic          progress_done_o;
  logic          err_o;

  modport master (
    output start_i, done_i, ci_done_i,
    input  lb_shift_o, win_valid_o, row_o, col_o, busy_o, progress_done_o, err_o
  );

  modport slave (
    input  start_i, done_i, ci_done_i,
    output lb_shift_o, win_valid_o, row_o, col_o, busy_o, progress_done_o, err_o
  );
endinterface

// File: rtl/mrelbp_ci_frame_ctrl.sv
// Raster-scan frame controller for the radius-6 MRELBP centre-intensity stage:
// tracks pixel position, strobes full-window valids and counts CI results.
//
// state | meaning
// IDLE  | waiting for start_i, not busy
// FILL  | accepting pixels, first 2*RADIUS rows not yet complete
// RUN   | accepting pixels, windows being issued
// DRAIN | all pixels in, waiting for outstanding CI results
// DONE  | one-cycle frame-complete pulse
module mrelbp_ci_frame_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int RADIUS = 6,
  parameter int CW     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  mrelbp_ci_frame_ctrl_if.slave  bus
);

  localparam int NUM_WIN = (IMG_H - 2*RADIUS) * (IMG_W - 2*RADIUS);
  localparam int RW      = $clog2(NUM_WIN + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE     = CW'(2*RADIUS);
  localparam logic [CW-1:0] RAD      = CW'(RADIUS);
  localparam logic [RW-1:0] RES_MAX  = RW'(NUM_WIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_row, w_row;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_res, w_res;
  logic          r_err, w_err;
  logic          r_lb_shift, w_lb_shift;
  logic          r_win_valid, w_win_valid;
  logic [CW-1:0] r_row_o, w_row_o;
  logic [CW-1:0] r_col_o, w_col_o;

  logic w_active;
  logic w_accept;
  logic w_ci_ok;
  logic w_err_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_lb_shift  <= 1'b0;
      r_win_valid <= 1'b0;
      r_row_o     <= '0;
      r_col_o     <= '0;
    end else begin
      r_state     <= w_state;
      r_row       <= w_row;
      r_col       <= w_col;
      r_res       <= w_res;
      r_err       <= w_err;
      r_lb_shift  <= w_lb_shift;
      r_win_valid <= w_win_valid;
      r_row_o     <= w_row_o;
      r_col_o     <= w_col_o;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_row       = r_row;
    w_col       = r_col;
    w_res       = r_res;
    w_err       = r_err;
    w_lb_shift  = 1'b0;
    w_win_valid = 1'b0;
    w_row_o     = r_row_o;
    w_col_o     = r_col_o;

    w_active = (r_state == S_FILL) || (r_state == S_RUN);
    w_accept = w_active && bus.done_i;
    w_ci_ok  = w_active || (r_state == S_DRAIN);

    // Result counter saturates at NUM_WIN; overflow is flagged as an error below.
    if (bus.ci_done_i && w_ci_ok && (r_res != RES_MAX)) begin
      w_res = r_res + 1'b1;
    end

    if (w_accept) begin
      w_lb_shift = 1'b1;
      if (r_col == LAST_COL) begin
        w_col = '0;
        w_row = r_row + 1'b1;
      end else begin
        w_col = r_col + 1'b1;
      end
      if ((r_row >= EDGE) && (r_col >= EDGE)) begin
        w_win_valid = 1'b1;
        w_row_o     = r_row - RAD;
        w_col_o     = r_col - RAD;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state = S_FILL;
          w_row   = '0;
          w_col   = '0;
          w_res   = '0;
          w_err   = 1'b0;
        end
      end
      S_FILL: begin
        if (w_accept && (r_row == EDGE) && (r_col == '0)) begin
          w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && (r_row == LAST_ROW) && (r_col == LAST_COL)) begin
          w_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Also covers the counter having filled up before the last pixel arrived.
        if (w_res == RES_MAX) begin
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_err_evt = (bus.done_i && !w_active)
              || (bus.start_i && (r_state != S_IDLE))
              || (bus.ci_done_i && (!w_ci_ok || (r_res == RES_MAX)));
    w_err = w_err | w_err_evt;
  end

  assign bus.lb_shift_o      = r_lb_shift;
  assign bus.win_valid_o     = r_win_valid;
  assign bus.row_o           = r_row_o;
  assign bus.col_o           = r_col_o;
  assign bus.busy_o          = (r_state != S_IDLE);
  assign bus.progress_done_o = (r_state == S_DONE);
  assign bus.err_o           = r_err;

endmodule

// File: tb/tb_mrelbp_ci_frame_ctrl.sv
// Scoreboard bench for mrelbp_ci_frame_ctrl: stimulus pushes expected windows,
// a negedge monitor pops and compares whenever win_valid_o is presented.
module tb_mrelbp_ci_frame_ctrl;

  typedef struct {
    int row;
    int col;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mrelbp_ci_frame_ctrl_if #(.CW(8)) bus();

  mrelbp_ci_frame_ctrl #(
    .IMG_W (16),
    .IMG_H (16),
    .RADIUS(6),
    .CW    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_win = 0;
  int   n_prog = 0;
  int   n_shift = 0;
  int   exp_prog_cyc = -1;
  int   tb_px = 0;
  int   ci_cnt = 0;
  bit   loop_en = 1'b0;
  bit   in_frame = 1'b0;
  logic [2:0] dl = '0;
  exp_t q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; ci_done_i loops back win_valid_o through a short delay line.
  task automatic step(input logic st, input logic dv, input logic ci_man);
    int r;
    int c;
    @(negedge clk);
    dl = {dl[1:0], bus.win_valid_o};
    bus.start_i   = st;
    bus.done_i    = dv;
    bus.ci_done_i = loop_en ? dl[2] : ci_man;
    if (loop_en && dl[2]) begin
      ci_cnt++;
      if (ci_cnt == 16) exp_prog_cyc = cyc + 1;
    end
    if (in_frame && dv) begin
      r = tb_px / 16;
      c = tb_px % 16;
      if (r >= 12 && c >= 12) q.push_back('{r - 6, c - 6, cyc + 1});
      tb_px++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.lb_shift_o) n_shift++;
      if (bus.win_valid_o) begin
        n_win++;
        if (q.size() == 0) begin
          check("win_unexpected", int'(bus.win_valid_o), 0);
        end else begin
          mon_e = q.pop_front();
          check("win_row", int'(bus.row_o), mon_e.row);
          check("win_col", int'(bus.col_o), mon_e.col);
          check("win_cycle", cyc, mon_e.cyc);
        end
      end
      if (bus.progress_done_o) begin
        n_prog++;
        check("prog_cycle", cyc, exp_prog_cyc);
      end
    end
  end

  task automatic run_frame(input bit stall, input int mid_start, input int exp_err);
    int w0;
    int p0;
    int s0;
    bit seen;
    w0 = n_win;
    p0 = n_prog;
    s0 = n_shift;
    dl = '0;
    ci_cnt = 0;
    exp_prog_cyc = -1;
    tb_px = 0;
    loop_en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    in_frame = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (stall) step(1'b0, 1'b0, 1'b0);
      step((i == mid_start) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    end
    in_frame = 1'b0;
    check("busy_after_pixels", int'(bus.busy_o), 1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.progress_done_o) seen = 1'b1;
    end
    check("prog_seen", int'(seen), 1);
    step(1'b0, 1'b0, 1'b0);
    check("busy_fall", int'(bus.busy_o), 0);
    step(1'b0, 1'b0, 1'b0);
    loop_en = 1'b0;
    check("win_count", n_win - w0, 16);
    check("prog_count", n_prog - p0, 1);
    check("shift_count", n_shift - s0, 256);
    check("queue_left", q.size(), 0);
    check("err_end", int'(bus.err_o), exp_err);
    check("row_hold", int'(bus.row_o), 9);
    check("col_hold", int'(bus.col_o), 9);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(bus.busy_o), 0);
    check({tag, "_err"}, int'(bus.err_o), 0);
    check({tag, "_win"}, int'(bus.win_valid_o), 0);
    check({tag, "_shift"}, int'(bus.lb_shift_o), 0);
    check({tag, "_prog"}, int'(bus.progress_done_o), 0);
    check({tag, "_row"}, int'(bus.row_o), 0);
    check({tag, "_col"}, int'(bus.col_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.start_i   = 1'b0;
    bus.done_i    = 1'b0;
    bus.ci_done_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("idle_px_err", int'(bus.err_o), 1);
    check("idle_px_noshift", int'(bus.lb_shift_o), 0);
    check("idle_px_busy", int'(bus.busy_o), 0);

    run_frame(1'b0, -1, 0);
    run_frame(1'b1, -1, 0);

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("extra_ci_err", int'(bus.err_o), 1);

    run_frame(1'b0, 100, 1);

    p0 = n_prog;
    dl = '0;
    ci_cnt = 0;
    tb_px = 0;
    loop_en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    in_frame = 1'b1;
    for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b0);
    in_frame = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("midframe_busy", int'(bus.busy_o), 1);
    rst = 1'b1;
    loop_en = 1'b0;
    bus.start_i   = 1'b0;
    bus.done_i    = 1'b0;
    bus.ci_done_i = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("midrst_no_prog", n_prog - p0, 0);
    check("midrst_idle", int'(bus.busy_o), 0);
    check("midrst_queue", q.size(), 0);

    run_frame(1'b0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mrelbp_ci_frame_ctrl.md
Name: mrelbp_ci_frame_ctrl

Overview:
Raster-scan frame controller for the radius-6 MRELBP centre-intensity (CI) stage. It counts the incoming pixel stream and tracks row and column. It tells the line buffers when to shift, and asserts the window-valid strobe that drives the CI unit's done_i once a full 13x13 neighbourhood exists. It counts CI results back from the unit and signals frame completion; it sits between the pixel source and the line-buffer/CI datapath.

Parameters:
IMG_W, 16, frame width in pixels (must be > 2*RADIUS)
IMG_H, 16, frame height in pixels (must be > 2*RADIUS)
RADIUS, 6, MRELBP radius; window side = 2*RADIUS+1
CW, 8, width of row/column counters (must hold max(IMG_W, IMG_H)-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start_i  in  1  begin a frame (accepted only in IDLE)
done_i  in  1  pixel valid: one pixel accepted per cycle when high
ci_done_i  in  1  result strobe from CI unit done_o
lb_shift_o  out  1  line-buffer shift enable
win_valid_o  out  1  window valid, drives CI unit done_i
row_o  out  CW  window-centre row for current win_valid_o
col_o  out  CW  window-centre column for current win_valid_o
busy_o  out  1  high from start accept until DONE exits
progress_done_o  out  1  one-cycle pulse: all CI results of the frame received
err_o  out  1  sticky protocol error, cleared on next accepted start_i

Behaviour:
- Reset is async. While rst is high, state = IDLE and every output = 0, including all counters and err_o.
- NUM_WIN = (IMG_H-2*RADIUS)*(IMG_W-2*RADIUS).
- States are IDLE, FILL, RUN, DRAIN and DONE.
- IDLE:
  - busy_o=0.
  - start_i=1 clears the pixel counters (r,c), the result counter and err_o, then moves to FILL.
- FILL/RUN pixel accept: done_i=1 accepts the pixel at (r,c).
  - Column wraps at IMG_W-1 to 0 with r+1.
  - lb_shift_o is a registered copy of accept, so it is high the cycle after the pixel.
- FILL -> RUN on accepting pixel (2*RADIUS, 0).
- Window valid: accepting pixel (r,c) with r >= 2*RADIUS and c >= 2*RADIUS drives the following on the next cycle:
  - win_valid_o=1;
  - row_o=r-RADIUS;
  - col_o=c-RADIUS.
- Latency is 1 cycle from accept to win_valid_o. row_o/col_o hold their last value when win_valid_o=0.
- RUN -> DRAIN on accepting pixel (IMG_H-1, IMG_W-1). That pixel's win_valid_o still issues.
- ci_done_i increments the result counter in FILL, RUN and DRAIN.
- DRAIN -> DONE in the cycle the counter reaches NUM_WIN. This includes the case where it is reached during RUN and the last pixel arrives later; the check is evaluated on entry to DRAIN.
- DONE:
  - progress_done_o=1 for exactly one cycle;
  - busy_o still 1;
  - next state IDLE.
- Errors (err_o set and held):
  - done_i=1 in IDLE, DRAIN or DONE: the pixel is ignored.
  - start_i=1 while busy: ignored, and the frame continues.
  - ci_done_i received when the counter already equals NUM_WIN, or outside FILL/RUN/DRAIN: the counter saturates.
- Simultaneous start_i and done_i in IDLE: the start is accepted, the pixel is ignored, and err_o is set.
- Gaps in done_i are allowed; counters hold.
- rst mid-frame aborts immediately to IDLE with all outputs 0, and no progress_done_o pulse.

Test Plan:
- Reset/idle: rst high 2 cycles, then low -> all outputs 0, busy_o=0.
- Nominal frame: IMG_W=IMG_H=16, RADIUS=6; start_i, then 256 back-to-back pixels; loop ci_done_i = win_valid_o delayed 3 cycles.
  - First win_valid_o comes the cycle after pixel index 204, with row_o=6, col_o=6.
  - Exactly 16 win_valid_o pulses; the last has row_o=9, col_o=9.
  - progress_done_o pulses once, 1 cycle after the 16th ci_done_i; busy_o falls the following cycle.
- Stalled stream: same frame, with done_i low every other cycle -> identical win_valid_o count and coordinates; lb_shift_o count = 256.
- Protocol errors:
  - done_i=1 in IDLE -> err_o=1 and no lb_shift_o.
  - start_i mid-frame -> err_o=1 and the frame completes normally.
  - Extra ci_done_i after 16 -> err_o=1.
- Reset mid-frame: rst after 150 pixels -> IDLE, outputs 0, no progress_done_o. A new start_i with a full 256-pixel frame then completes correctly with err_o=0.
